// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and mux-select encodings for the multicycle control unit
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_deco.sv
// rtl/imm_src_deco.sv - opcode to immediate-format select, independent of FSM state
module imm_src_deco
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_multiciclo.sv
// rtl/ctrl_fsm_multiciclo.sv - multicycle RV32I main control FSM with req/ready memory handshake
module ctrl_fsm_multiciclo
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state, state_next;
  logic   pc_update, branch;
  logic   mem_req_s, ir_write_s, reg_write_s, mem_write_s, illegal_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_req_s   = 1'b0;
    AdrSrc      = 1'b0;
    ir_write_s  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    illegal_s   = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        // IR and PC load only on the completing cycle, so a stall never repeats them
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_next  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: illegal_s = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  // Reset forces state to FETCH asynchronously; gate strobes so nothing fires meanwhile
  assign mem_req   = mem_req_s & ~reset;
  assign IRWrite   = ir_write_s & ~reset;
  assign PCWrite   = (pc_update | (branch & zero)) & ~reset;
  assign RegWrite  = reg_write_s & ~reset;
  assign MemWrite  = mem_write_s & ~reset;
  assign illegal   = illegal_s & ~reset;
  assign state_dbg = STATE_W'(state);

  imm_src_deco u_imm_src_deco (
    .op      (op),
    .imm_src (ImmSrc)
  );

endmodule

// File: tb/tb_ctrl_fsm_multiciclo.sv
// tb/tb_ctrl_fsm_multiciclo.sv - self-checking bench for ctrl_fsm_multiciclo
module tb_ctrl_fsm_multiciclo;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1110011;

  logic       clk, reset, zero, mem_ready;
  logic [6:0] op;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state_dbg;
  logic [16:0] outs;
  int checks = 0;
  int errors = 0;

  ctrl_fsm_multiciclo #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  assign outs = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output table as listed for each numbered state
  function automatic logic [16:0] exp_out(input int st, input logic mr, input logic z,
                                          input logic [6:0] o, input logic rst);
    logic mq, adr, irw, pcw, rgw, mw, ill;
    logic [1:0] res, sa, sb, aop, imm;
    {mq, adr, irw, pcw, rgw, mw, ill} = '0;
    {res, sa, sb, aop} = '0;
    imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
    case (st)
      0:  begin mq = 1; sb = 2; res = 2; irw = mr; pcw = mr; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  begin mq = 1; adr = 1; end
      4:  begin res = 1; rgw = 1; end
      5:  begin mq = 1; adr = 1; mw = 1; end
      6:  begin sa = 2; aop = 2; end
      7:  begin sa = 2; sb = 1; aop = 2; end
      8:  rgw = 1;
      9:  begin sa = 2; aop = 1; pcw = z; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      11: ill = 1;
      default: ;
    endcase
    if (rst) {mq, irw, pcw, rgw, mw, ill} = '0;
    return {mq, adr, irw, pcw, rgw, mw, res, sa, sb, aop, imm, ill};
  endfunction

  // Runs one instruction from FETCH; fs/ms <0 picks random stall counts
  task automatic run_instr(input logic [6:0] o, input logic z, input int fs, input int ms);
    int path[$];
    int idx = 0, cyc = 0, irc = 0, pcc = 0, rwc = 0, rwd = 0;
    int fs0, ms0, exp_cyc, exp_pc, exp_rw, st;
    logic mr;
    case (o)
      LW:      path = '{0, 1, 2, 3, 4};
      SW:      path = '{0, 1, 2, 5};
      RT:      path = '{0, 1, 6, 8};
      IT:      path = '{0, 1, 7, 8};
      BQ:      path = '{0, 1, 9};
      JL:      path = '{0, 1, 10, 8};
      default: path = '{0, 1, 11};
    endcase
    if (fs < 0) fs = $urandom_range(0, 3);
    if (ms < 0) ms = $urandom_range(0, 3);
    fs0 = fs;
    ms0 = (o == LW || o == SW) ? ms : 0;
    exp_cyc = path.size() + fs0 + ms0;
    exp_pc  = 1 + ((o == BQ && z) ? 1 : 0) + ((o == JL) ? 1 : 0);
    exp_rw  = (o == LW || o == RT || o == IT || o == JL) ? 1 : 0;
    op = o;
    zero = z;
    while (idx < path.size() && cyc < 60) begin
      st = path[idx];
      if (st == 0)                mr = (fs == 0);
      else if (st == 3 || st == 5) mr = (ms == 0);
      else                        mr = 1'($urandom_range(0, 1));
      mem_ready = mr;
      #1;
      chk("state", 32'(state_dbg), 32'(st));
      chk("outputs", 32'(outs), 32'(exp_out(st, mr, z, o, 1'b0)));
      irc += int'(IRWrite);
      pcc += int'(PCWrite);
      rwc += int'(RegWrite);
      if (RegWrite && ResultSrc == 2'b01) rwd++;
      if (st == 0 && !mr) fs--;
      else if ((st == 3 || st == 5) && !mr) ms--;
      else idx++;
      cyc++;
      @(posedge clk); #2;
    end
    chk("cycles", 32'(cyc), 32'(exp_cyc));
    chk("irwrite_cnt", 32'(irc), 32'd1);
    chk("pcwrite_cnt", 32'(pcc), 32'(exp_pc));
    chk("regwrite_cnt", 32'(rwc), 32'(exp_rw));
    chk("regwrite_data_cnt", 32'(rwd), (o == LW) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] o;
    ops = '{LW, SW, RT, IT, BQ, JL};
    reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_outputs", 32'(outs), 32'(exp_out(0, 1'b1, 1'b0, 7'd0, 1'b1)));
    @(posedge clk); #2;
    reset = 1'b0;

    run_instr(RT, 1'b0, 0, 0);
    run_instr(LW, 1'b0, 2, 3);
    run_instr(BQ, 1'b1, 0, 0);
    run_instr(BQ, 1'b0, 0, 0);
    run_instr(JL, 1'b0, 0, 0);
    run_instr(SW, 1'b0, 1, 2);

    // Abandon an R-type in EXECR with an asynchronous reset
    op = RT; mem_ready = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("pre_reset_state", 32'(state_dbg), 32'd6);
    reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(state_dbg), 32'd0);
    chk("async_reset_outputs", 32'(outs), 32'(exp_out(0, 1'b1, zero, RT, 1'b1)));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("reset_regwrite", 32'(RegWrite), 32'd0);
      chk("reset_hold_state", 32'(state_dbg), 32'd0);
    end
    reset = 1'b0;

    for (int n = 0; n < 25; n++) begin
      o = ops[$urandom_range(0, 5)];
      run_instr(o, 1'($urandom_range(0, 1)), -1, -1);
    end

    run_instr(BAD, 1'b0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      chk("trap_state", 32'(state_dbg), 32'd11);
      chk("trap_outputs", 32'(outs), 32'(exp_out(11, mem_ready, zero, BAD, 1'b0)));
      @(posedge clk); #2;
    end
    reset = 1'b1;
    #1;
    chk("trap_reset_state", 32'(state_dbg), 32'd0);
    chk("trap_reset_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    run_instr(IT, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_multiciclo.md
Name: ctrl_fsm_multiciclo

Overview:
- Main control unit for the multicycle RV32I core.
- It sequences each instruction through fetch/decode/execute/memory/writeback states and drives ALUOp[1:0] (00 add, 01 sub, 10 decode-by-funct) into the existing ALU decoder, plus all datapath mux selects and write enables.
- Supports lw, sw, R-type, I-type ALU, beq and jal. Any other opcode traps.
- Memory accesses use a req/ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state_dbg output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  7  instr[6:0] taken from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- mem_req  output  1  memory access request.
- AdrSrc  output  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  instruction register load enable.
- PCWrite  output  1  PC load enable.
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  data memory write enable.
- ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  output  2  ALU B select: 00 rs2, 01 ImmExt, 10 constant 4.
- ALUOp  output  2  to the ALU decoder.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal  output  1  trap indicator, sticky.
- state_dbg  output  STATE_W  current state encoding.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Reset (async): state goes to FETCH immediately.
  - While reset is high, mem_req, IRWrite, PCWrite, RegWrite, MemWrite and illegal are all 0.
  - Other outputs take the FETCH values.
  - Reset mid-instruction abandons it; no write enable may pulse afterwards.
- Outputs are Moore decodes of state, except IRWrite, PCWrite, MemWrite and RegWrite, which are qualified as listed below.
- Any field not listed for a state is driven 0; no X is ever driven.
- PCWrite = PCUpdate | (Branch & zero). PCUpdate and Branch are internal.
- Per-state outputs:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCUpdate = mem_ready. Hold in FETCH until mem_ready; then go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1. Hold until mem_ready; then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Then FETCH.
  - MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 for every cycle in this state. Leave to FETCH on mem_ready.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Then FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Then FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Then ALUWB (writes rd = PC+4).
  - TRAP: illegal=1, all enables 0. Sticky until reset.
- ImmSrc is a combinational decode of op in every state:
  - lw / I-type → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - otherwise → 00
- Latency in cycles with mem_ready tied to 1:
  - lw = 5
  - sw = 4
  - R-type / I-type = 4
  - beq = 3
  - jal = 4
- Each stall cycle where mem_ready=0 adds 1 cycle. No enable repeats during a stall: IRWrite and PCWrite pulse exactly once per fetch.
- mem_ready is ignored in non-memory states.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp codes ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - the ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
- One sub-module, imm_src_deco: combinational op → ImmSrc.

Test Plan:
- Reset is asserted mid-EXECR (state_dbg=6) → state_dbg goes to 0 without waiting for a clock edge; RegWrite stays 0 through the next 3 cycles.
- op=0110011, mem_ready=1 → state sequence 0,1,6,8,0; ALUOp=10 in state 6; RegWrite=1 only in state 8; exactly one IRWrite pulse.
- op=0000011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD → total of 10 cycles; IRWrite=1 exactly once; RegWrite with ResultSrc=01 exactly once.
- op=1100011 with zero=1 → PCWrite=1 in BEQ with ALUOp=01. Repeat with zero=0 → PCWrite=0 in BEQ.
- op=1101111 → states 0,1,10,8; PCWrite=1 in JAL; ALUSrcB=10; RegWrite=1 in ALUWB; ImmSrc=11 throughout.
- op=1110011 → TRAP (state 11), illegal=1, held for 20 cycles with all enables 0; reset returns the FSM to FETCH with illegal=0.
